mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_if.sv | 30 +++
 rtl/mem_arb.sv | 50 +++++
 tb/tb_mem_arb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared bus sizes and response owner tag encoding
package mem_arb_pkg;
  localparam int SIZE_ADDR = 8;
  localparam int SIZE_DATA = 8;
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, data-access and memory-port signals of the arbiter
interface mem_arb_if;
  import mem_arb_pkg::*;
  logic                 iw_f_req;
  logic [SIZE_ADDR-1:0] iw_f_addr;
  logic                 ow_f_gnt;
  logic                 ow_f_rvalid;
  logic                 iw_d_req;
  logic                 iw_d_we;
  logic [SIZE_ADDR-1:0] iw_d_addr;
  logic [SIZE_DATA-1:0] iw_d_wdata;
  logic                 ow_d_gnt;
  logic                 ow_d_rvalid;
  logic [SIZE_DATA-1:0] ow_rdata;
  logic                 ow_mem_we;
  logic [SIZE_ADDR-1:0] ow_mem_addr;
  logic [SIZE_DATA-1:0] ow_mem_wdata;
  logic [SIZE_DATA-1:0] iw_mem_rdata;
  logic                 ow_stall_f;
  modport master (
    output iw_f_req, iw_f_addr, iw_d_req, iw_d_we, iw_d_addr, iw_d_wdata, iw_mem_rdata,
    input  ow_f_gnt, ow_f_rvalid, ow_d_gnt, ow_d_rvalid, ow_rdata,
           ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_stall_f
  );
  modport slave (
    input  iw_f_req, iw_f_addr, iw_d_req, iw_d_we, iw_d_addr, iw_d_wdata, iw_mem_rdata,
    output ow_f_gnt, ow_f_rvalid, ow_d_gnt, ow_d_rvalid, ow_rdata,
           ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_stall_f
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter, data over fetch with fetch starvation guard
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic       iw_clk,
  input  logic       iw_rst,
  mem_arb_if.slave   bus
);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0]     wait_q, wait_d;
  owner_e               tag_q, tag_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d;
  logic [SIZE_DATA-1:0] wdata_q, wdata_d;
  logic                 f_gnt, d_gnt;
  // grant selection, wait counter, owner tag and held memory-port values
  always_comb begin
    f_gnt   = !iw_rst && bus.iw_f_req && (wait_q == MAX_W || !bus.iw_d_req);
    d_gnt   = !iw_rst && bus.iw_d_req && !f_gnt;
    wait_d  = (!bus.iw_f_req || f_gnt) ? '0 : (wait_q == MAX_W ? wait_q : wait_q + 1'b1);
    tag_d   = f_gnt ? OWN_FETCH : (d_gnt && !bus.iw_d_we) ? OWN_DATA : OWN_NONE;
    addr_d  = d_gnt ? bus.iw_d_addr : f_gnt ? bus.iw_f_addr : addr_q;
    wdata_d = d_gnt ? bus.iw_d_wdata : wdata_q;
  end
  // state registers; reset drops any pending response
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wait_q  <= '0;
      tag_q   <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wait_q  <= wait_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.ow_f_gnt     = f_gnt;
  assign bus.ow_d_gnt     = d_gnt;
  assign bus.ow_stall_f   = !iw_rst && bus.iw_f_req && !f_gnt;
  assign bus.ow_mem_we    = d_gnt && bus.iw_d_we;
  assign bus.ow_mem_addr  = addr_d;
  assign bus.ow_mem_wdata = wdata_d;
  assign bus.ow_f_rvalid  = tag_q == OWN_FETCH;
  assign bus.ow_d_rvalid  = tag_q == OWN_DATA;
  assign bus.ow_rdata     = bus.iw_mem_rdata;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: table-driven arbiter bench with a read-response scoreboard
module tb_mem_arb;
  import mem_arb_pkg::*;
  typedef logic [SIZE_ADDR-1:0] addr_t;
  typedef logic [SIZE_DATA-1:0] data_t;
  typedef struct {
    logic  f, d, we;
    addr_t fa, da;
    data_t wd;
    logic  efg, edg;
  } vec_t;
  typedef struct {
    owner_e own;
    data_t  data;
  } rsp_t;
  logic  clk = 1'b0;
  logic  rst;
  int    tests = 0;
  int    fails = 0;
  data_t mem [256];
  data_t exp_mem [256];
  rsp_t  sb [$];
  addr_t last_addr;
  data_t last_wdata;
  vec_t  tbl [25];
  mem_arb_if bus();
  mem_arb #(.MAX_WAIT(4), .CNT_W(3)) dut (.iw_clk(clk), .iw_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ow_mem_we) mem[bus.ow_mem_addr] <= bus.ow_mem_wdata;
    bus.iw_mem_rdata <= mem[bus.ow_mem_addr];
  end
  function automatic vec_t v(logic f, logic d, logic we, addr_t fa, addr_t da, data_t wd,
                             logic efg, logic edg);
    vec_t r;
    r.f = f; r.d = d; r.we = we; r.fa = fa; r.da = da; r.wd = wd; r.efg = efg; r.edg = edg;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    bus.iw_f_req   = x.f;
    bus.iw_d_req   = x.d;
    bus.iw_d_we    = x.we;
    bus.iw_f_addr  = x.fa;
    bus.iw_d_addr  = x.da;
    bus.iw_d_wdata = x.wd;
  endtask
  task automatic step(input vec_t x);
    rsp_t  e;
    addr_t ea;
    @(negedge clk);
    drive(x);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("f_rvalid", 32'(bus.ow_f_rvalid), 32'(e.own == OWN_FETCH));
      check("d_rvalid", 32'(bus.ow_d_rvalid), 32'(e.own == OWN_DATA));
      check("rdata", 32'(bus.ow_rdata), 32'(e.data));
    end else
      check("no_rvalid", 32'({bus.ow_f_rvalid, bus.ow_d_rvalid}), 32'd0);
    ea = x.efg ? x.fa : x.edg ? x.da : last_addr;
    check("f_gnt", 32'(bus.ow_f_gnt), 32'(x.efg));
    check("d_gnt", 32'(bus.ow_d_gnt), 32'(x.edg));
    check("stall_f", 32'(bus.ow_stall_f), 32'(x.f && !x.efg));
    check("mem_we", 32'(bus.ow_mem_we), 32'(x.edg && x.we));
    check("mem_addr", 32'(bus.ow_mem_addr), 32'(ea));
    check("mem_wdata", 32'(bus.ow_mem_wdata), 32'(x.edg ? x.wd : last_wdata));
    last_addr = ea;
    if (x.edg) last_wdata = x.wd;
    if (x.efg) sb.push_back('{OWN_FETCH, exp_mem[x.fa]});
    if (x.edg && !x.we) sb.push_back('{OWN_DATA, exp_mem[x.da]});
    if (x.edg && x.we) exp_mem[x.da] = x.wd;
  endtask
  task automatic reset_seq();
    @(negedge clk);
    rst = 1'b1;
    drive(v(1, 1, 1, 8'h11, 8'h22, 8'h33, 0, 0));
    #1;
    check("rst_f_gnt", 32'(bus.ow_f_gnt), 32'd0);
    check("rst_d_gnt", 32'(bus.ow_d_gnt), 32'd0);
    check("rst_rvalid", 32'({bus.ow_f_rvalid, bus.ow_d_rvalid}), 32'd0);
    check("rst_mem_we", 32'(bus.ow_mem_we), 32'd0);
    check("rst_stall", 32'(bus.ow_stall_f), 32'd0);
    check("rst_mem_addr", 32'(bus.ow_mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.ow_mem_wdata), 32'd0);
    sb.delete();
    last_addr = '0;
    last_wdata = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    #1;
    check("post_rst_rvalid", 32'({bus.ow_f_rvalid, bus.ow_d_rvalid}), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    drive(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    for (int i = 0; i < 256; i++) begin
      mem[i] = data_t'(i) ^ 8'hA5;
      exp_mem[i] = data_t'(i) ^ 8'hA5;
    end
    tbl[0]  = v(1, 0, 0, 8'h10, 8'h00, 8'h00, 1, 0);
    tbl[1]  = v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[2]  = v(1, 1, 1, 8'h11, 8'h20, 8'h5A, 0, 1);
    tbl[3]  = v(1, 1, 0, 8'h11, 8'h20, 8'h00, 0, 1);
    tbl[4]  = v(1, 1, 0, 8'h11, 8'h21, 8'h00, 0, 1);
    tbl[5]  = v(1, 1, 0, 8'h11, 8'h22, 8'h00, 0, 1);
    tbl[6]  = v(1, 1, 0, 8'h11, 8'h23, 8'h00, 1, 0);
    tbl[7]  = v(1, 1, 0, 8'h12, 8'h24, 8'h00, 0, 1);
    tbl[8]  = v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[9]  = v(0, 1, 0, 8'h00, 8'h30, 8'h00, 0, 1);
    tbl[10] = v(1, 0, 0, 8'h31, 8'h00, 8'h00, 1, 0);
    tbl[11] = v(0, 1, 0, 8'h00, 8'h32, 8'h00, 0, 1);
    tbl[12] = v(1, 0, 0, 8'h33, 8'h00, 8'h00, 1, 0);
    tbl[13] = v(0, 1, 1, 8'h00, 8'h34, 8'hC3, 0, 1);
    tbl[14] = v(0, 1, 0, 8'h00, 8'h34, 8'h00, 0, 1);
    tbl[15] = v(1, 1, 0, 8'h40, 8'h35, 8'h00, 0, 1);
    tbl[16] = v(1, 1, 0, 8'h40, 8'h36, 8'h00, 0, 1);
    tbl[17] = v(0, 1, 0, 8'h40, 8'h37, 8'h00, 0, 1);
    tbl[18] = v(1, 1, 0, 8'h40, 8'h38, 8'h00, 0, 1);
    tbl[19] = v(1, 1, 0, 8'h40, 8'h39, 8'h00, 0, 1);
    tbl[20] = v(1, 1, 0, 8'h40, 8'h3A, 8'h00, 0, 1);
    tbl[21] = v(1, 1, 0, 8'h40, 8'h3B, 8'h00, 0, 1);
    tbl[22] = v(1, 1, 0, 8'h40, 8'h3C, 8'h00, 1, 0);
    tbl[23] = v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[24] = v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    reset_seq();
    for (int i = 0; i < 25; i++) step(tbl[i]);
    step(v(1, 0, 0, 8'h50, 8'h00, 8'h00, 1, 0));
    reset_seq();
    for (int i = 0; i < 4; i++) step(v(1, 1, 0, 8'h60, 8'h61, 8'h00, 0, 1));
    step(v(1, 1, 0, 8'h60, 8'h61, 8'h00, 1, 0));
    step(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    step(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
